// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared types and digit limits for the stopwatch engine
// Revision 1.0
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX_DEC = 4'd9;
  localparam bcd_t DIGIT_MAX_SEX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_if.sv
`default_nettype none
// ============================================================================
// stopwatch_core_if : button/tick inputs and MM:SS.cc display outputs
// Revision 1.0
// ============================================================================
interface stopwatch_core_if;
  import stopwatch_pkg::*;

  logic tick_in;
  logic start_stop;
  logic clear;
  logic lap;
  bcd_t cs_ones, cs_tens;
  bcd_t s_ones, s_tens;
  bcd_t m_ones, m_tens;
  logic running;
  logic lap_hold;
  logic overflow;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    input  running, lap_hold, overflow
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    output running, lap_hold, overflow
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// bcd_digit_counter : one BCD digit 0..MAX with ripple carry to the next digit
// Revision 1.0
// ============================================================================
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_DEC
) (
  input  wire logic cin,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic carry_in,
  output bcd_t      digit,
  output logic      carry_out
);

  bcd_t count;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (carry_in) begin
      count <= (count == MAX) ? '0 : count + 4'd1;
    end
  end

  assign digit     = count;
  assign carry_out = carry_in & (count == MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// stopwatch_core : centisecond stopwatch (MM:SS.cc) with synchronized inputs.
// Optional lap hold enabled by defining STOPWATCH_LAP_EN.  Revision 1.0
// ============================================================================
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  wire logic       cin,
  input  wire logic       rst,
  stopwatch_core_if.slave sw
);

`ifdef STOPWATCH_LAP_EN
  localparam int NIN = 4;
`else
  localparam int NIN = 3;
`endif
  localparam int              TICK      = 0;
  localparam int              SS        = 1;
  localparam int              CLR       = 2;
  localparam logic [NIN-1:0]  TICK_MASK = NIN'(1);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_q [SYNC_STAGES];
  logic [NIN-1:0] prev_q;
  logic [NIN-1:0] edge_q;
  logic [NIN-1:0] sync_last;

`ifdef STOPWATCH_LAP_EN
  assign raw = {sw.lap, sw.clear, sw.start_stop, sw.tick_in};
`else
  assign raw = {sw.clear, sw.start_stop, sw.tick_in};
`endif
  assign sync_last = sync_q[SYNC_STAGES-1];

  // Buttons register rising edges only; tick_in registers both edges.
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last;
      edge_q <= (sync_last & ~prev_q) | (~sync_last & prev_q & TICK_MASK);
    end
  end

  logic tick_edge, ss_edge, clr_edge;
  assign tick_edge = edge_q[TICK];
  assign ss_edge   = edge_q[SS];
  assign clr_edge  = edge_q[CLR];

  state_t state, state_next;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr_edge) begin
      state_next = IDLE;
    end else if (ss_edge) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // The pre-transition state gates counting, so a tick with start_stop in RUN still counts.
  logic inc;
  assign inc = tick_edge & (state == RUN) & ~clr_edge;

  bcd_t       live [6];
  logic [5:0] carry;

  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_cs_ones (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(inc),
    .digit(live[0]), .carry_out(carry[0]));
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_cs_tens (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(carry[0]),
    .digit(live[1]), .carry_out(carry[1]));
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_s_ones (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(carry[1]),
    .digit(live[2]), .carry_out(carry[2]));
  bcd_digit_counter #(.MAX(DIGIT_MAX_SEX)) u_s_tens (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(carry[2]),
    .digit(live[3]), .carry_out(carry[3]));
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_m_ones (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(carry[3]),
    .digit(live[4]), .carry_out(carry[4]));
  bcd_digit_counter #(.MAX(DIGIT_MAX_SEX)) u_m_tens (
    .cin(cin), .rst(rst), .clear(clr_edge), .carry_in(carry[4]),
    .digit(live[5]), .carry_out(carry[5]));

  logic overflow_q;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= carry[5];
  end

  bcd_t disp [6];
  logic hold;

`ifdef STOPWATCH_LAP_EN
  logic lap_edge;
  bcd_t held [6];

  assign lap_edge = edge_q[3];

  // Leaving RUN for PAUSE also drops the hold so a paused display shows the live count.
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      for (int i = 0; i < 6; i++) held[i] <= '0;
    end else if (clr_edge || (ss_edge && state == RUN)) begin
      hold <= 1'b0;
    end else if (lap_edge && state == RUN) begin
      hold <= ~hold;
      if (!hold) held <= live;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) disp[i] = hold ? held[i] : live[i];
  end
`else
  assign hold = 1'b0;

  always_comb begin
    for (int i = 0; i < 6; i++) disp[i] = live[i];
  end
`endif

  assign sw.cs_ones  = disp[0];
  assign sw.cs_tens  = disp[1];
  assign sw.s_ones   = disp[2];
  assign sw.s_tens   = disp[3];
  assign sw.m_ones   = disp[4];
  assign sw.m_tens   = disp[5];
  assign sw.running  = (state == RUN);
  assign sw.lap_hold = hold;
  assign sw.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_core : directed self-checking bench for stopwatch_core
// Revision 1.0
// ============================================================================
module tb_stopwatch_core;

  logic cin = 1'b0;
  logic rst = 1'b1;

  stopwatch_core_if sw ();

  stopwatch_core #(.SYNC_STAGES(2)) dut (
    .cin(cin),
    .rst(rst),
    .sw (sw.slave)
  );

  always #5 cin = ~cin;

  int tests  = 0;
  int failed = 0;
  int ov_count = 0;
  logic [23:0] ov_digits = 24'hFFFFFF;

`ifdef STOPWATCH_LAP_EN
  localparam logic [23:0] EXP_HELD = 24'h000005;
  localparam logic        EXP_HOLD = 1'b1;
`else
  localparam logic [23:0] EXP_HELD = 24'h000025;
  localparam logic        EXP_HOLD = 1'b0;
`endif

  function automatic logic [23:0] disp();
    return {sw.m_tens, sw.m_ones, sw.s_tens, sw.s_ones, sw.cs_tens, sw.cs_ones};
  endfunction

  always @(negedge cin) begin
    if (sw.overflow === 1'b1) begin
      ov_count  <= ov_count + 1;
      ov_digits <= disp();
    end
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge cin);
  endtask

  task automatic press(input int which);
    case (which)
      0:       sw.start_stop = 1'b1;
      1:       sw.clear      = 1'b1;
      default: sw.lap        = 1'b1;
    endcase
    cycles(6);
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
    cycles(6);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sw.tick_in = ~sw.tick_in;
      cycles(8);
    end
  endtask

  initial begin
    sw.tick_in    = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;

    // reset state
    cycles(3);
    check("rst_digits", disp(), 24'h0);
    check("rst_running", 24'(sw.running), 24'h0);
    rst = 1'b0;
    cycles(4);
    check("post_rst_digits", disp(), 24'h0);
    check("post_rst_lap_hold", 24'(sw.lap_hold), 24'h0);
    check("post_rst_overflow", 24'(sw.overflow), 24'h0);

    // 100 ticks in RUN -> 00:01.00
    press(0);
    check("start_running", 24'(sw.running), 24'h1);
    ticks(100);
    check("count_100", disp(), 24'h000100);
    check("count_100_running", 24'(sw.running), 24'h1);
    check("no_overflow_yet", 24'(ov_count), 24'h0);

    // preload 59:59.99 and wrap
    force dut.u_m_tens.count  = 4'd5;
    force dut.u_m_ones.count  = 4'd9;
    force dut.u_s_tens.count  = 4'd5;
    force dut.u_s_ones.count  = 4'd9;
    force dut.u_cs_tens.count = 4'd9;
    force dut.u_cs_ones.count = 4'd9;
    cycles(1);
    release dut.u_m_tens.count;
    release dut.u_m_ones.count;
    release dut.u_s_tens.count;
    release dut.u_s_ones.count;
    release dut.u_cs_tens.count;
    release dut.u_cs_ones.count;
    cycles(1);
    ticks(1);
    check("wrap_digits", disp(), 24'h000000);
    check("wrap_overflow_cycles", 24'(ov_count), 24'h1);
    check("wrap_overflow_digits", ov_digits, 24'h000000);
    check("wrap_running", 24'(sw.running), 24'h1);

    // start_stop and tick detected together in RUN at 00:00.41
    press(1);
    press(0);
    ticks(41);
    check("count_41", disp(), 24'h000041);
    sw.start_stop = 1'b1;
    sw.tick_in    = ~sw.tick_in;
    cycles(8);
    check("ss_tick_digits", disp(), 24'h000042);
    check("ss_tick_running", 24'(sw.running), 24'h0);
    sw.start_stop = 1'b0;
    cycles(6);
    ticks(5);
    check("paused_hold_count", disp(), 24'h000042);

    // clear coincident with tick and start_stop at 00:12.34
    press(1);
    press(0);
    ticks(1234);
    check("count_1234", disp(), 24'h001234);
    sw.clear      = 1'b1;
    sw.start_stop = 1'b1;
    sw.tick_in    = ~sw.tick_in;
    cycles(8);
    check("clr_digits", disp(), 24'h0);
    check("clr_running", 24'(sw.running), 24'h0);
    check("clr_lap_hold", 24'(sw.lap_hold), 24'h0);
    sw.clear      = 1'b0;
    sw.start_stop = 1'b0;
    cycles(6);

    // lap hold
    press(0);
    ticks(5);
    check("lap_pre", disp(), 24'h000005);
    press(2);
    ticks(20);
    check("lap_held_digits", disp(), EXP_HELD);
    check("lap_held_flag", 24'(sw.lap_hold), 24'(EXP_HOLD));
    press(2);
    check("lap_release_digits", disp(), 24'h000025);
    check("lap_release_flag", 24'(sw.lap_hold), 24'h0);
    press(0);
    press(2);
    check("lap_in_pause_ignored", 24'(sw.lap_hold), 24'h0);
    check("lap_in_pause_digits", disp(), 24'h000025);

    // asynchronous reset mid-run at 00:03.07
    press(1);
    press(0);
    ticks(307);
    check("count_307", disp(), 24'h000307);
    @(posedge cin);
    #2 rst = 1'b1;
    #1;
    check("async_rst_digits", disp(), 24'h0);
    check("async_rst_running", 24'(sw.running), 24'h0);
    check("async_rst_overflow", 24'(sw.overflow), 24'h0);
    cycles(3);
    rst = 1'b0;
    ticks(10);
    check("idle_after_rst_digits", disp(), 24'h0);
    check("idle_after_rst_running", 24'(sw.running), 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
# stopwatch_core

Centisecond stopwatch engine for the DE10-Lite display path. It consumes the divided square wave from the 10 ms clock divider and counts one centisecond per edge, synchronously in the 50 MHz domain. It also synchronizes and edge-detects the start/stop, clear and lap push-buttons. It drives six BCD digits (MM:SS.cc) to the seven-segment decoders.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2)

Ports:
- cin  in  1  50 MHz system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  divided clock from the 10 ms divider; each edge (rise or fall) is one centisecond
- start_stop  in  1  button level, active-high; rising edge toggles run/pause
- clear  in  1  button level, active-high; rising edge zeroes and idles
- lap  in  1  button level, active-high; rising edge toggles display hold
- cs_ones, cs_tens  out  4 each  centisecond BCD digits
- s_ones, s_tens  out  4 each  seconds BCD digits
- m_ones, m_tens  out  4 each  minutes BCD digits
- running  out  1  high in RUN state
- lap_hold  out  1  high while the display is frozen
- overflow  out  1  one-cycle pulse on wrap 59:59.99 → 00:00.00

## Operation
- Every input passes through a SYNC_STAGES synchronizer, then a one-register edge detector.
- tick_in uses both edges. Buttons use the rising edge only.
- FSM states:
  - IDLE (reset state): count is zero.
  - RUN
  - PAUSE
- FSM transitions:
  - start_stop edge: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - clear edge: any state→IDLE, zeroes all count digits, releases lap hold.
- Counting:
  - A tick edge increments the count only while the current state is RUN. The state before any same-cycle transition decides.
  - Digit limits: cs_ones 0–9, cs_tens 0–9, s_ones 0–9, s_tens 0–5, m_ones 0–9, m_tens 0–5.
  - Each digit carries into the next digit when it rolls over.
  - A full rollover from 59:59.99 returns the count to 00:00.00, pulses overflow for one cycle, and stays in RUN.
- Simultaneous events in one cycle:
  - clear edge beats a start_stop edge, a lap edge and a tick edge. Result: IDLE, zero count, no increment.
  - start_stop edge together with a tick edge while in RUN: the tick is counted, then the state becomes PAUSE.
- Digit outputs are the displayed value: the live count, or the held snapshot while lap_hold=1.
- Reset values: all digits 0, running 0, lap_hold 0, overflow 0, state IDLE, synchronizers and edge registers 0.
- Reset asserted mid-count returns everything to these values immediately. No edge is detected on the first cycle after reset release.

## Timing
- Input change to detected edge pulse: SYNC_STAGES+1 cycles. With the default this is 3 cycles.
- Edge pulse to updated digits, state, running or lap_hold: 1 cycle.
- Total latency for the default configuration: 4 cycles from an input transition to visible outputs.
- overflow is asserted in the same cycle as the wrapped digits appear.
- Inputs must be stable at least SYNC_STAGES+2 cycles between transitions.
  - tick_in meets this by construction (500 000-cycle half period).
  - Button bounce is not filtered here.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap edge in RUN captures the live count into a hold register and sets lap_hold=1.
  - The outputs show the held value while the internal count keeps running.
  - A second lap edge, a transition into PAUSE, or clear releases the hold.
  - A lap edge in IDLE or PAUSE is ignored.
- STOPWATCH_LAP_EN undefined:
  - The lap input is unused and there is no hold register.
  - lap_hold is tied to 0 and the outputs always show the live count.

## Structure
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE)
  - 4-bit bcd_t typedef
  - constants DIGIT_MAX_DEC=9 and DIGIT_MAX_SEX=5
- Sub-module bcd_digit_counter:
  - parameter MAX
  - inputs: clear and carry_in (enable)
  - outputs: digit and carry_out, where carry_out = carry_in & (digit==MAX)
  - instantiated six times in a carry chain.
- Synchronizers and edge detectors stay inline in the top module.

## Test plan
- Reset, start_stop edge, then 100 tick_in edges (bench toggles tick_in every 8 cycles) → 00:01.00, running=1, overflow never asserted.
- Preload to 59:59.99 via 359 999 ticks in RUN, then one more edge → 00:00.00, overflow high exactly one cycle, running=1.
- start_stop edge and a tick edge detected in the same cycle from RUN, count at 00:00.41 → 00:00.42 and running=0 next cycle; further ticks leave 00:00.42.
- clear edge coincident with a tick and a start_stop edge at 00:12.34 → 00:00.00, running=0, lap_hold=0.
- LAP_EN: RUN at 00:00.05, lap edge, then 20 ticks → outputs stay 00:00.05 with lap_hold=1; second lap edge → outputs 00:00.25, lap_hold=0. Without LAP_EN the same stimulus gives 00:00.25 and lap_hold=0 throughout.
- Assert rst mid-run at 00:03.07 → all outputs 0 asynchronously; after release, ticks with no start_stop edge leave 00:00.00.
